// File: rtl/out_word_collector.sv
// Assembles framed MSB-first serial bits into WIDTH-bit words and queues them in a
// DEPTH-entry show-ahead FIFO; flags discarded partial words and words dropped on a full FIFO.
module out_word_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     BIT_IN,
  input  logic                     BIT_VALID,
  input  logic                     FRAME_START,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     FRAME_ERR,
  output logic                     OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    SHIFT    = 1'b1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_dout;
  logic             r_ferr;
  logic             r_ovf;

  logic             w_restart;
  logic             w_shift_bit;
  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_nxt;
  logic [AW:0]      w_lvl_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_restart   = BIT_VALID && FRAME_START;
  assign w_shift_bit = (r_state == SHIFT) && BIT_VALID && !FRAME_START;
  assign w_done      = w_shift_bit && (r_cnt == LAST_CNT);
  assign w_word      = {r_shift, BIT_IN};
  assign w_pop       = (r_level != '0) && DOUT_READY;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign w_push      = w_done && ((r_level != FULL_LVL) || w_pop);
  assign w_rd_nxt    = w_pop ? r_rd + AW'(1) : r_rd;

  always_comb begin
    w_lvl_nxt = r_level;
    if (w_push && !w_pop) begin
      w_lvl_nxt = r_level + (AW + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_lvl_nxt = r_level - (AW + 1)'(1);
    end
  end

  // The word being written becomes the head only when it lands at the new read slot.
  assign w_head_nxt = (w_push && (r_wr == w_rd_nxt)) ? w_word : r_mem[w_rd_nxt];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ferr <= (r_state == SHIFT) && w_restart;
      if (w_restart) begin
        r_state <= SHIFT;
        r_cnt   <= CW'(1);
        r_shift <= (WIDTH - 1)'(BIT_IN);
      end else if (w_shift_bit) begin
        if (w_done) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_shift <= '0;
        end else begin
          r_cnt   <= r_cnt + CW'(1);
          r_shift <= w_word[WIDTH-2:0];
        end
      end
      if (w_done && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      r_dout  <= '0;
    end else begin
      r_rd    <= w_rd_nxt;
      r_level <= w_lvl_nxt;
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_lvl_nxt != '0) begin
        r_dout <= w_head_nxt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr] <= w_word;
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = (r_level != '0);
  assign LEVEL      = r_level;
  assign FRAME_ERR  = r_ferr;
  assign OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_out_word_collector.sv
// Directed bench for out_word_collector with a queue-based reference model checked every cycle.
module tb_out_word_collector;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic BIT_IN = 1'b0;
  logic BIT_VALID = 1'b0;
  logic FRAME_START = 1'b0;
  logic DOUT_READY = 1'b0;
  logic [WIDTH-1:0] DOUT;
  logic DOUT_VALID;
  logic [$clog2(DEPTH):0] LEVEL;
  logic FRAME_ERR;
  logic OVERFLOW;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_seen = 0;
  logic [WIDTH-1:0] drained [$];

  out_word_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
    .FRAME_START(FRAME_START), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY), .LEVEL(LEVEL), .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus a bit accumulator for the frame in progress.
  int unsigned m_q [$];
  int unsigned m_acc = 0;
  int unsigned m_word = 0;
  int          m_nbits = 0;
  bit          m_in_frame = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  bit          m_ferr = 0;
  int unsigned m_last = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_q.delete();
      m_acc = 0; m_nbits = 0; m_in_frame = 0; m_ovf = 0; m_ferr = 0; m_last = 0;
    end else begin
      m_done = 0;
      m_ferr = 0;
      if (BIT_VALID) begin
        if (FRAME_START) begin
          m_ferr = m_in_frame;
          m_in_frame = 1;
          m_acc = 32'(BIT_IN);
          m_nbits = 1;
        end else if (m_in_frame) begin
          m_acc = m_acc * 2 + 32'(BIT_IN);
          m_nbits++;
          if (m_nbits == WIDTH) begin
            m_done = 1;
            m_word = m_acc;
            m_in_frame = 0;
          end
        end
      end
      if (m_q.size() > 0 && DOUT_READY) void'(m_q.pop_front());
      if (m_done) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_word);
        else m_ovf = 1;
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
  end

  always @(negedge CLK) begin
    check("dout_valid", 32'(DOUT_VALID), 32'(m_q.size() > 0));
    check("level", 32'(LEVEL), 32'(m_q.size()));
    check("overflow", 32'(OVERFLOW), 32'(m_ovf));
    check("frame_err", 32'(FRAME_ERR), 32'(m_ferr));
    check("dout", 32'(DOUT), m_last);
    if (FRAME_ERR) ferr_seen++;
  end

  task automatic send_bit(input logic b, input logic fs, input int gap);
    BIT_IN = b; FRAME_START = fs; BIT_VALID = 1'b1;
    @(posedge CLK); #1;
    BIT_VALID = 1'b0; FRAME_START = 1'b0; BIT_IN = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit gapped, input logic rdy_last);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) DOUT_READY = rdy_last;
      send_bit(w[WIDTH-1-i], i == 0, (gapped && i != WIDTH - 1) ? i % 4 : 0);
    end
    DOUT_READY = 1'b0;
  endtask

  task automatic drain();
    drained.delete();
    DOUT_READY = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      @(negedge CLK);
      if (!DOUT_VALID) break;
      drained.push_back(DOUT);
      @(posedge CLK); #1;
    end
    DOUT_READY = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic rst_pulse();
    #2 RST = 1'b0;
    #4 RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    repeat (6) begin
      @(posedge CLK); #1;
      BIT_IN = 1'($urandom); BIT_VALID = 1'($urandom);
      FRAME_START = 1'($urandom); DOUT_READY = 1'($urandom);
    end
    @(negedge CLK);
    check("rst_valid", 32'(DOUT_VALID), 0);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_overflow", 32'(OVERFLOW), 0);
    check("rst_frame_err", 32'(FRAME_ERR), 0);
    check("rst_dout", 32'(DOUT), 0);
    @(posedge CLK); #1;
    BIT_IN = 1'b0; BIT_VALID = 1'b0; FRAME_START = 1'b0; DOUT_READY = 1'b0;
    RST = 1'b1;

    send_word(8'hA5, 0, 1'b0);
    @(negedge CLK);
    check("basic_dout", 32'(DOUT), 32'h A5);
    check("basic_valid", 32'(DOUT_VALID), 1);
    check("basic_level", 32'(LEVEL), 1);
    check("model_basic", m_last, 32'h A5);
    @(posedge CLK); #1;
    drain();
    check("basic_drain_cnt", 32'(drained.size()), 1);

    send_word(8'h3C, 1, 1'b0);
    @(negedge CLK);
    check("gap_dout", 32'(DOUT), 32'h3C);
    check("gap_level", 32'(LEVEL), 1);
    @(posedge CLK); #1;
    drain();

    ferr_seen = 0;
    send_bit(1'b0, 1'b1, 0);
    send_bit(1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b0, 0);
    send_word(8'hC3, 0, 1'b0);
    @(negedge CLK);
    check("ferr_pulses", 32'(ferr_seen), 1);
    check("ferr_level", 32'(LEVEL), 1);
    check("ferr_dout", 32'(DOUT), 32'h C3);
    @(posedge CLK); #1;
    drain();
    check("ferr_drain_cnt", 32'(drained.size()), 1);

    for (int w = 1; w <= 5; w++) send_word(WIDTH'(w), 0, 1'b0);
    @(negedge CLK);
    check("ovf_level", 32'(LEVEL), 4);
    check("ovf_flag", 32'(OVERFLOW), 1);
    check("model_ovf", 32'(m_ovf), 1);
    @(posedge CLK); #1;
    drain();
    check("ovf_drain_cnt", 32'(drained.size()), 4);
    for (int i = 0; i < 4 && i < drained.size(); i++)
      check("ovf_drain_word", 32'(drained[i]), 32'(i + 1));
    check("ovf_sticky", 32'(OVERFLOW), 1);
    rst_pulse();

    for (int w = 'h11; w <= 'h14; w++) send_word(WIDTH'(w), 0, 1'b0);
    send_word(8'h15, 0, 1'b1);
    @(negedge CLK);
    check("fullpop_level", 32'(LEVEL), 4);
    check("fullpop_ovf", 32'(OVERFLOW), 0);
    check("fullpop_head", 32'(DOUT), 32'h12);
    @(posedge CLK); #1;
    drain();
    check("fullpop_drain_cnt", 32'(drained.size()), 4);
    for (int i = 0; i < 4 && i < drained.size(); i++)
      check("fullpop_word", 32'(drained[i]), 32'h12 + 32'(i));

    send_word(8'h21, 0, 1'b0);
    send_word(8'h22, 0, 1'b0);
    send_bit(1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 0);
    #2 RST = 1'b0;
    #1;
    check("arst_level", 32'(LEVEL), 0);
    check("arst_valid", 32'(DOUT_VALID), 0);
    check("arst_dout", 32'(DOUT), 0);
    #3 RST = 1'b1;
    @(posedge CLK); #1;
    send_word(8'h7E, 0, 1'b0);
    @(negedge CLK);
    check("post_rst_dout", 32'(DOUT), 32'h7E);
    check("post_rst_level", 32'(LEVEL), 1);
    check("post_rst_ovf", 32'(OVERFLOW), 0);
    @(posedge CLK); #1;
    drain();
    check("post_rst_drain_cnt", 32'(drained.size()), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
